alu_seq: RTL
============

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter W, default 4, operand width in bits; legal range 2..16.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request strobe; sampled only when busy=0.
REQ-005 A  input  W  operand A; latched on accepted start.
REQ-006 B  input  W  operand B; latched on accepted start.
REQ-007 Sel  input  4  opcode; latched on accepted start.
REQ-008 busy  output  1  multi-cycle multiply in progress.
REQ-009 done  output  1  one-cycle pulse; result outputs valid and updated.
REQ-010 F3  output  W  result, or low half of product.
REQ-011 F4  output  W  high half of product; zero for all other ops.
REQ-012 C  output  1  carry (ADD) or borrow (SUB).
REQ-013 V  output  1  signed two's-complement overflow (ADD/SUB).
REQ-014 Z  output  1  result-is-zero flag.
REQ-015 err  output  1  opcode not in the supported set.

Function
REQ-016 Opcodes SHALL be: 0001 ADD, 0011 SUB (A-B), 0111 MUL (unsigned), 1000 NAND, 1001 NOR, 1011 XOR; new in this generation: 1010 AND, 1101 OR.
REQ-017 Any other opcode SHALL complete as a single-cycle op with F3=F4=0, C=V=0, Z=1, err=1.
REQ-018 err SHALL be 0 for every supported opcode.
REQ-019 States SHALL be IDLE and MUL only.
REQ-020 IDLE + start + non-MUL opcode: stay IDLE, register result; done=1 in the next cycle (latency 1).
REQ-021 IDLE + start + MUL: go to MUL; busy=1 from the next cycle for exactly W cycles.
REQ-022 MUL state: shift-add, one multiplier bit per cycle, LSB first, W-bit iteration counter.
REQ-023 After W iterations: return to IDLE, busy=0, {F4,F3}=A*B (2W bits), done=1 in the cycle after the last busy cycle (latency W+1).
REQ-024 start while busy=1 SHALL be ignored; latched operands and opcode are unaffected.
REQ-025 start in the same cycle as done=1 (busy=0) SHALL be accepted (back-to-back issue).
REQ-026 Result outputs (F3, F4, C, V, Z, err) SHALL change only in the done cycle and hold until the next done.
REQ-027 ADD: F3=(A+B) mod 2^W; C = carry out of bit W-1; V=1 when the operand signs are equal and the result sign differs.
REQ-028 SUB: F3=(A-B) mod 2^W; C=1 iff A<B unsigned; V=1 when the operand signs differ and the result sign differs from A.
REQ-029 MUL and the logic ops SHALL force C=V=0.
REQ-030 Z SHALL be 1 iff F3==0 (non-MUL ops) or {F4,F3}==0 (MUL).
REQ-031 Input changes after an accepted start SHALL NOT affect the running operation.

Reset
REQ-032 While rst=1: state=IDLE, counter=0, busy=0, done=0, F3=F4=0, C=V=Z=err=0; start is ignored.
REQ-033 rst asserted during MUL SHALL abort the operation; no done pulse for the aborted operation.
REQ-034 The first start after rst deasserts SHALL be accepted normally.

Verification (W=4)
REQ-035 ADD A=0111 B=1001 -> next cycle done=1, F3=0000, C=1, V=0, Z=1.
REQ-036 ADD A=0111 B=0001 -> F3=1000, C=0, V=1; SUB A=0011 B=0101 -> F3=1110, C=1, V=0.
REQ-037 MUL A=1111 B=1111 -> busy=1 for 4 cycles, done in cycle 5, F4=1110, F3=0001, Z=0.
REQ-038 During MUL, pulse start with Sel=0001 -> ignored; MUL result unchanged; a start in the done cycle -> accepted, done one cycle later.
REQ-039 rst in MUL cycle 2 -> all outputs 0 next cycle, no done; Sel=1111 start -> F3=F4=0, Z=1, err=1.
REQ-040 NAND/NOR/XOR/AND/OR with A=1100 B=1010 -> 0111/0001/0110/1000/1110, C=V=0, err=0.

Source files
------------

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle add/sub/logic ops and a W-cycle shift-add unsigned multiply.
// Results and flags are registered and presented together with a one-cycle done pulse.
module alu_seq #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic [3:0]   Sel,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] F3,
  output logic [W-1:0] F4,
  output logic         C,
  output logic         V,
  output logic         Z,
  output logic         err
);

  typedef enum logic {IDLE, MUL} state_t;

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0001,
    OP_SUB  = 4'b0011,
    OP_MUL  = 4'b0111,
    OP_NAND = 4'b1000,
    OP_NOR  = 4'b1001,
    OP_AND  = 4'b1010,
    OP_XOR  = 4'b1011,
    OP_OR   = 4'b1101
  } op_t;

  localparam logic [W-1:0] CNT_LAST = W[W-1:0] - 1'b1;

  state_t         state, state_next;
  logic [W-1:0]   cnt;
  logic [W-1:0]   mcand;
  logic [2*W-1:0] prod;
  logic [2*W-1:0] prod_step;
  logic [W:0]     partial;

  logic [W-1:0]   r_f;
  logic           r_c, r_v, r_z, r_err;
  logic [W:0]     sum, diff;

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic; a start is only seen while IDLE, so starts during MUL are dropped.
  always_comb begin
    // NOTE: default assignment first keeps this block free of inferred latches.
    state_next = state;
    case (state)
      IDLE: if (start && Sel == OP_MUL) state_next = MUL;
      MUL:  if (cnt == CNT_LAST)        state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state == MUL);
  end

  // Single-cycle result path, evaluated directly on the inputs presented with start.
  always_comb begin
    r_f   = '0;
    r_c   = 1'b0;
    r_v   = 1'b0;
    r_err = 1'b0;
    sum   = {1'b0, A} + {1'b0, B};
    diff  = {1'b0, A} - {1'b0, B};
    case (Sel)
      OP_ADD: begin
        r_f = sum[W-1:0];
        r_c = sum[W];
        r_v = (A[W-1] == B[W-1]) && (sum[W-1] != A[W-1]);
      end
      OP_SUB: begin
        r_f = diff[W-1:0];
        r_c = diff[W];
        r_v = (A[W-1] != B[W-1]) && (diff[W-1] != A[W-1]);
      end
      OP_MUL:  r_f = '0;
      OP_NAND: r_f = ~(A & B);
      OP_NOR:  r_f = ~(A | B);
      OP_AND:  r_f = A & B;
      OP_XOR:  r_f = A ^ B;
      OP_OR:   r_f = A | B;
      default: r_err = 1'b1;
    endcase
    r_z = (r_f == '0);
  end

  // One shift-add step: add the multiplicand into the high half when the current
  // multiplier bit (LSB of prod) is set, then shift the whole product right by one.
  always_comb begin
    partial   = {1'b0, prod[2*W-1:W]} + (prod[0] ? {1'b0, mcand} : '0);
    prod_step = {partial, prod[W-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      mcand <= '0;
      prod  <= '0;
      done  <= 1'b0;
      F3    <= '0;
      F4    <= '0;
      C     <= 1'b0;
      V     <= 1'b0;
      Z     <= 1'b0;
      err   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          if (Sel == OP_MUL) begin
            mcand <= A;
            prod  <= {{W{1'b0}}, B};
            cnt   <= '0;
          end else begin
            F3   <= r_f;
            F4   <= '0;
            C    <= r_c;
            V    <= r_v;
            Z    <= r_z;
            err  <= r_err;
            done <= 1'b1;
          end
        end
        MUL: begin
          prod <= prod_step;
          cnt  <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            cnt  <= '0;
            F3   <= prod_step[W-1:0];
            F4   <= prod_step[2*W-1:W];
            C    <= 1'b0;
            V    <= 1'b0;
            Z    <= (prod_step == '0);
            err  <= 1'b0;
            done <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule
